float_to_fixed_decoder: RTL and testbench



---
 rtl/float_pkg.sv | 16 +
 rtl/float_shift_unit.sv | 40 ++++
 rtl/float_to_fixed_decoder.sv | 78 +++++++
 tb/tb_float_to_fixed_decoder.sv | 120 ++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared definitions for the float encode/decode datapath.
//   D_W   : width of the two's-complement fixed-point value
//   E_W   : exponent width (shift count 0 .. 2^E_W-1)
//   F_W   : unsigned mantissa width
//   state_e : decoder FSM encoding
package float_pkg;
   localparam int D_W = 12;
   localparam int E_W = 3;
   localparam int F_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_e;
endpackage

// File: rtl/float_shift_unit.sv
// Iterative magnitude rebuilder: one left shift per enabled cycle.
//   clk, rst_n : clock, async active-low reset
//   load       : capture zero-extended f into mag and e into cnt
//   shift      : mag <<= 1, cnt -= 1 (caller only asserts while !done)
//   f, e       : mantissa / exponent to load
//   mag        : current magnitude
//   done       : no shifts remain (cnt == 0)
module float_shift_unit
   import float_pkg::*;
#(
   parameter int DW = D_W,
   parameter int EW = E_W,
   parameter int FW = F_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          shift,
   input  logic [FW-1:0] f,
   input  logic [EW-1:0] e,
   output logic [DW-1:0] mag,
   output logic          done
);
   logic [EW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag <= '0;
         cnt <= '0;
      end else if (load) begin
         mag <= {{(DW-FW){1'b0}}, f};
         cnt <= e;
      end else if (shift) begin
         mag <= mag << 1;
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);
endmodule

// File: rtl/float_to_fixed_decoder.sv
// Rebuilds a two's-complement value D_out = (S ? -1 : 1) * (F << E) from
// float fields, one shift per cycle, with valid/ready on both sides.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : input handshake; S/E/F sampled on acceptance only
//   S, E, F             : sign, exponent (shift count), mantissa
//   out_valid/out_ready : output handshake; D_out held stable until consumed
//   D_out               : reconstructed value
module float_to_fixed_decoder
   import float_pkg::*;
#(
   parameter int DW = D_W,
   parameter int EW = E_W,
   parameter int FW = F_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          S,
   input  logic [EW-1:0] E,
   input  logic [FW-1:0] F,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] D_out
);
   state_e        state, nxt;
   logic          sign;
   logic          load, shift, done;
   logic [DW-1:0] mag;

   float_shift_unit #(.DW(DW), .EW(EW), .FW(FW)) u_shift (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .shift (shift),
      .f     (F),
      .e     (E),
      .mag   (mag),
      .done  (done)
   );

   assign in_ready = (state == IDLE);

   always_comb begin
      nxt   = state;
      load  = 1'b0;
      shift = 1'b0;
      case (state)
         IDLE:  if (in_valid) begin
                   load = 1'b1;
                   nxt  = SHIFT;
                end
         SHIFT: if (!done) shift = 1'b1;
                else       nxt   = HOLD;
         HOLD:  if (out_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sign      <= 1'b0;
         out_valid <= 1'b0;
         D_out     <= '0;
      end else begin
         state <= nxt;
         if (load) sign <= S;
         if (state == SHIFT && done) begin
            // -0 negates to 0, so negative zero needs no special case
            D_out     <= sign ? (~mag + 1'b1) : mag;
            out_valid <= 1'b1;
         end else if (state == HOLD && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_float_to_fixed_decoder.sv
module tb_float_to_fixed_decoder;
   logic        clk = 0;
   logic        rst_n;
   logic        in_valid, in_ready, S, out_valid, out_ready;
   logic [2:0]  E;
   logic [3:0]  F;
   logic [11:0] D_out;
   int          tests = 0, fails = 0;

   float_to_fixed_decoder dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .S(S), .E(E), .F(F), .out_valid(out_valid), .out_ready(out_ready),
      .D_out(D_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: sign applied to F*2^E, 12-bit two's complement
   function automatic logic [11:0] ref_val(input logic s, input logic [2:0] e, input logic [3:0] f);
      logic [11:0] m;
      m = 12'(f) << e;
      return s ? 12'(12'd0 - m) : m;
   endfunction

   // Accept one float, measure latency, check result, consume it.
   task automatic decode(input string tag, input logic s, input logic [2:0] e,
                         input logic [3:0] f, input logic [11:0] exp);
      int cyc;
      @(negedge clk);
      S = s; E = e; F = f; in_valid = 1; out_ready = 0;
      chk({tag, " in_ready_pre"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 0; S = ~s; E = ~e; F = ~f;  // later changes must be ignored
      chk({tag, " in_ready_busy"}, in_ready, 0);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, " latency"}, cyc, e + 1);
      chk({tag, " D_out"}, D_out, exp);
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk({tag, " out_valid_clr"}, out_valid, 0);
      chk({tag, " in_ready_back"}, in_ready, 1);
   endtask

   initial begin
      rst_n = 0; in_valid = 0; out_ready = 0; S = 0; E = 0; F = 0;
      #2;
      chk("rst in_ready", in_ready, 1);
      chk("rst out_valid", out_valid, 0);
      chk("rst D_out", D_out, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1;

      decode("p240", 0, 3'd4, 4'hF, 12'h0F0);
      decode("n240", 1, 3'd4, 4'hF, 12'hF10);
      decode("n1920", 1, 3'd7, 4'hF, 12'h880);
      decode("p5", 0, 3'd0, 4'h5, 12'h005);
      decode("negzero", 1, 3'd3, 4'h0, 12'h000);
      decode("p1920", 0, 3'd7, 4'hF, 12'h780);

      // Backpressure: result must hold while out_ready is low
      @(negedge clk);
      S = 0; E = 3'd2; F = 4'h7; in_valid = 1; out_ready = 0;
      @(posedge clk); #1;
      in_valid = 0;
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
      chk("bp first valid", out_valid, 1);
      S = 1; E = 3'd7; F = 4'hF;
      for (int i = 0; i < 4; i++) begin
         in_valid = ~in_valid;
         @(posedge clk); #1;
         chk("bp out_valid", out_valid, 1);
         chk("bp D_out", D_out, 12'h01C);
         chk("bp in_ready", in_ready, 0);
      end
      in_valid = 0; out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk("bp released valid", out_valid, 0);
      chk("bp released ready", in_ready, 1);

      // Reset during SHIFT discards the in-flight result
      @(negedge clk);
      S = 1; E = 3'd7; F = 4'hF; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      @(posedge clk); @(posedge clk); #1;
      chk("mid busy", in_ready, 0);
      rst_n = 0;
      #1;
      chk("mid rst in_ready", in_ready, 1);
      chk("mid rst out_valid", out_valid, 0);
      chk("mid rst D_out", D_out, 0);
      @(negedge clk);
      rst_n = 1;
      decode("after rst", 0, 3'd1, 4'h8, 12'h010);

      // Exhaustive sweep of all S/E/F codes against the reference
      for (int c = 0; c < 256; c++) begin
         logic [7:0] code;
         code = 8'(c);
         decode("sweep", code[7], code[6:4], code[3:0], ref_val(code[7], code[6:4], code[3:0]));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
